// File: rtl/gem_sync_err_mon.sv
// GEM sync-flag monitor: per-channel LOCKED/SUSPECT/UNLOCKED debounce with hysteresis,
// plus saturating bad-frame and lock-loss counters for VME readout.

module gem_sync_err_ch #(
  parameter int BAD_THRESH  = 4,
  parameter int GOOD_THRESH = 16,
  parameter int CNT_W       = 16,
  parameter int UNL_W       = 8
) (
  input  logic             clock,
  input  logic             global_reset_n,
  input  logic             ttc_resync,
  input  logic             cnt_clear,
  input  logic             sample,
  output logic [1:0]       state,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt,
  output logic [UNL_W-1:0] unlock_cnt
);
  localparam logic [1:0] ST_LOCKED   = 2'd0;
  localparam logic [1:0] ST_SUSPECT  = 2'd1;
  localparam logic [1:0] ST_UNLOCKED = 2'd2;
  localparam logic [8:0] BAD_T  = 9'(BAD_THRESH);
  localparam logic [8:0] GOOD_T = 9'(GOOD_THRESH);

  logic [1:0] st_q, st_nxt;
  logic [7:0] run_q, run_nxt;
  logic [8:0] run_p1;
  logic       bad;
  logic       enter_unl;

  assign bad    = ~sample;
  assign run_p1 = {1'b0, run_q} + 9'd1;

  always_ff @(posedge clock) begin
    if (!global_reset_n || ttc_resync) begin
      st_q  <= ST_LOCKED;
      run_q <= '0;
    end else begin
      st_q  <= st_nxt;
      run_q <= run_nxt;
    end
  end

  always_comb begin
    st_nxt  = st_q;
    run_nxt = run_q;
    case (st_q)
      ST_LOCKED: begin
        if (bad && BAD_T == 9'd1) begin
          st_nxt  = ST_UNLOCKED;
          run_nxt = '0;
        end else if (bad) begin
          st_nxt  = ST_SUSPECT;
          run_nxt = 8'd1;
        end else begin
          run_nxt = '0;
        end
      end
      ST_SUSPECT: begin
        if (bad && run_p1 == BAD_T) begin
          st_nxt  = ST_UNLOCKED;
          run_nxt = '0;
        end else if (bad) begin
          run_nxt = run_p1[7:0];
        end else begin
          st_nxt  = ST_LOCKED;
          run_nxt = '0;
        end
      end
      ST_UNLOCKED: begin
        if (!bad && run_p1 == GOOD_T) begin
          st_nxt  = ST_LOCKED;
          run_nxt = '0;
        end else if (!bad) begin
          run_nxt = run_p1[7:0];
        end else begin
          run_nxt = '0;
        end
      end
      default: begin
        st_nxt  = ST_LOCKED;
        run_nxt = '0;
      end
    endcase
  end

  always_comb begin
    state     = st_q;
    locked    = (st_q != ST_UNLOCKED);
    enter_unl = (st_nxt == ST_UNLOCKED) && (st_q != ST_UNLOCKED);
  end

  // A clear wins over a same-cycle increment.
  always_ff @(posedge clock) begin
    if (!global_reset_n || ttc_resync || cnt_clear) begin
      err_cnt    <= '0;
      unlock_cnt <= '0;
    end else begin
      if (bad && err_cnt != '1)          err_cnt    <= err_cnt + 1'b1;
      if (enter_unl && unlock_cnt != '1) unlock_cnt <= unlock_cnt + 1'b1;
    end
  end
endmodule

module gem_sync_err_mon #(
  parameter int BAD_THRESH  = 4,
  parameter int GOOD_THRESH = 16,
  parameter int CNT_W       = 16,
  parameter int UNL_W       = 8
) (
  input  logic             clock,
  input  logic             global_reset_n,
  input  logic             ttc_resync,
  input  logic             cnt_clear,
  input  logic             mon_en,
  input  logic             gemA_synced,
  input  logic             gemB_synced,
  input  logic             gems_synced,
  output logic             gemA_locked,
  output logic             gemB_locked,
  output logic             gems_locked,
  output logic [5:0]       sync_state,
  output logic [CNT_W-1:0] gemA_err_cnt,
  output logic [CNT_W-1:0] gemB_err_cnt,
  output logic [CNT_W-1:0] gems_err_cnt,
  output logic [UNL_W-1:0] gemA_unlock_cnt,
  output logic [UNL_W-1:0] gemB_unlock_cnt,
  output logic [UNL_W-1:0] gems_unlock_cnt
);
  localparam int NUM_CH = 3;

  logic [NUM_CH-1:0]            s1_q;
  logic [NUM_CH-1:0][1:0]       st;
  logic [NUM_CH-1:0]            lk;
  logic [NUM_CH-1:0][CNT_W-1:0] err;
  logic [NUM_CH-1:0][UNL_W-1:0] unl;

  // Disabled monitor presents all-good samples, so FSMs settle and counters freeze.
  always_ff @(posedge clock) begin
    if (!global_reset_n || ttc_resync || !mon_en) s1_q <= '1;
    else s1_q <= {gems_synced, gemB_synced, gemA_synced};
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gem_sync_err_ch #(
      .BAD_THRESH(BAD_THRESH), .GOOD_THRESH(GOOD_THRESH), .CNT_W(CNT_W), .UNL_W(UNL_W)
    ) u_ch (
      .clock(clock), .global_reset_n(global_reset_n), .ttc_resync(ttc_resync),
      .cnt_clear(cnt_clear), .sample(s1_q[c]), .state(st[c]), .locked(lk[c]),
      .err_cnt(err[c]), .unlock_cnt(unl[c])
    );
  end

  assign sync_state      = st;
  assign {gems_locked, gemB_locked, gemA_locked} = lk;
  assign gemA_err_cnt    = err[0];
  assign gemB_err_cnt    = err[1];
  assign gems_err_cnt    = err[2];
  assign gemA_unlock_cnt = unl[0];
  assign gemB_unlock_cnt = unl[1];
  assign gems_unlock_cnt = unl[2];
endmodule
